// File: rtl/mux_pkg.sv
// Shared mux/demux types: source-select width, source count and the round-robin pick.
// The sel_t encoding matches the 1-to-4 demux select (bit 1 = S1, bit 0 = S0).
package mux_pkg;
  localparam int SEL_W = 2;
  localparam int N_SRC = 4;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Walks from farthest offset (last itself) down to last+1 so the nearest requester wins.
  function automatic sel_t rr_pick(input logic [N_SRC-1:0] req, input sel_t last);
    sel_t pick;
    sel_t idx;
    pick = last;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = last + sel_t'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_mux4_if.sv
// Four-source valid/ready bundle merged into one tagged output stream.
// master drives the sources and the sink ready; slave is the multiplexer.
interface rr_mux4_if #(parameter int W = 8);
  import mux_pkg::*;

  logic [N_SRC-1:0]   in_valid;
  logic [N_SRC-1:0]   in_ready;
  logic [N_SRC*W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  sel_t               out_sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb4.sv
// Combinational round-robin picker: zero latency, no state, no backpressure of its own.
// Search starts one past last; any reports whether sel is meaningful.
module rr_arb4
  import mux_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             last,
  output sel_t             sel,
  output logic             any
);
  always_comb begin
    sel = rr_pick(req, last);
    any = |req;
  end
endmodule

// File: rtl/rr_mux4.sv
// 4:1 round-robin mux with a registered, source-tagged output; a word taken at edge N is
// visible right after N. Stalls all sources while the output is held; drains and loads on one edge.
module rr_mux4
  import mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_mux4_if.slave   bus
);
  state_t       state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;
  sel_t         out_sel_q, out_sel_d;
  sel_t         last_q, last_d;
  sel_t         sel;
  logic         any;
  logic         load;
  logic         gnt;

  rr_arb4 u_arb (
    .req  (bus.in_valid),
    .last (last_q),
    .sel  (sel),
    .any  (any)
  );

  // rst_n gates the grant so nothing is handed a ready while reset is asserted.
  always_comb begin
    load         = (state_q == ST_EMPTY) || bus.out_ready;
    gnt          = rst_n && load && any;
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_d       = last_q;
    bus.in_ready = '0;
    if (gnt) begin
      bus.in_ready = {{(N_SRC-1){1'b0}}, 1'b1} << sel;
      out_data_d   = bus.in_data[W*int'(sel) +: W];
      out_sel_d    = sel;
      last_d       = sel;
      state_d      = ST_FULL;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      last_q     <= sel_t'(N_SRC - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      last_q     <= last_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux4.sv
// Scoreboard bench for rr_mux4: granted words are queued at the grant edge and
// popped when the sink consumes them; directed sequences cover hold, fairness and reset.
module tb_rr_mux4;
  logic clk;
  logic rst_n;

  rr_mux4_if #(.W(8)) bus ();

  rr_mux4 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp;
  int         n_bad;
  logic       m_full;
  int         m_last;
  logic [3:0] obs_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [7:0] d);
    bus.in_data[i*8 +: 8] = d;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    logic [3:0] exp_rdy;
    int         sel;
    logic       load;
    exp_t       e;
    #1;
    exp_rdy = '0;
    sel     = 0;
    load    = !m_full || bus.out_ready;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
    if (rst_n && load) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (bus.in_valid[idx] && exp_rdy == 4'd0) begin
          exp_rdy = 4'd1 << idx;
          sel     = idx;
        end
      end
    end
    chk("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    obs_rdy = bus.in_ready;
    if (!rst_n) begin
      sb.delete();
      m_full = 1'b0;
      m_last = 3;
    end else begin
      if (m_full && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_size", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
          chk("out_sel", {30'd0, bus.out_sel}, {30'd0, e.sel});
        end
        m_full = 1'b0;
      end
      if (exp_rdy != 4'd0) begin
        e.sel  = 2'(sel);
        e.data = bus.in_data[sel*8 +: 8];
        sb.push_back(e);
        m_full = 1'b1;
        m_last = sel;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    m_full = 1'b0;
    m_last = 3;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step();
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_sel", {30'd0, bus.out_sel}, 32'd0);
    rst_n = 1'b1;

    // Full contention: strict 0,1,2,3,0 order with no bubbles.
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 8'h30 + 8'(i));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_order", {28'd0, obs_rdy}, {28'd0, rr_exp[c]});
    end

    // Load 0xA5 from source 2, then stall the sink with every source valid.
    bus.in_valid = 4'b0100;
    set_src(2, 8'hA5);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_data", {24'd0, bus.out_data}, 32'hA5);
      chk("hold_sel", {30'd0, bus.out_sel}, 32'd2);
      chk("hold_rdy", {28'd0, obs_rdy}, 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0000;
    step();

    // Lone source 3 streaming back to back.
    bus.in_valid = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      set_src(3, 8'h10 + 8'(c));
      step();
      chk("stream_vld", {31'd0, bus.out_valid}, 32'd1);
    end
    // Nothing requesting while the last word drains: output empties.
    bus.in_valid = 4'b0000;
    step();
    chk("drain_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_rdy", {28'd0, obs_rdy}, 32'd0);

    // After source 1 wins, source 0 precedes it.
    bus.in_valid = 4'b0010;
    set_src(1, 8'h5C);
    set_src(0, 8'hC3);
    step();
    bus.in_valid = 4'b0011;
    step();
    chk("rr_after1", {28'd0, obs_rdy}, 32'b0001);
    bus.in_valid = 4'b0000;
    step();

    // Reset while a word is held and the sink is stalled.
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    set_src(0, 8'h77);
    step();
    bus.in_valid = 4'b1111;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 4'b0000;
    chk("rst2_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rst2_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst2_sel", {30'd0, bus.out_sel}, 32'd0);
    bus.in_valid  = 4'b1010;
    bus.out_ready = 1'b1;
    set_src(1, 8'h91);
    set_src(3, 8'hE3);
    step();
    chk("rst2_first", {28'd0, obs_rdy}, 32'b0010);
    bus.in_valid = 4'b0000;
    step();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
